div_ctrl: RTL and testbench
===========================

# div_ctrl

Iterative 32-bit divider controller for the EX stage, the companion to the ALU for the planned div/mod opcodes (div.w, mod.w, div.wu, mod.wu). It accepts one request at a time over a valid/ready handshake and sequences a restoring shift-subtract datapath one quotient bit per cycle. It applies sign correction and returns quotient and remainder together over a second valid/ready handshake. EX holds the instruction while `div_busy` is high and selects quotient or remainder itself.

## Interface
No parameters; width is fixed at 32.
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- div_valid  in  1  request valid from EX
- div_ready  out  1  unit can accept a request (high only in IDLE)
- div_signed  in  1  1 = signed (div.w/mod.w), 0 = unsigned
- div_src1  in  32  dividend (rj)
- div_src2  in  32  divisor (rk)
- div_flush  in  1  cancel any in-flight operation (exception/ertn)
- res_valid  out  1  quotient/remainder valid
- res_ready  in  1  EX consumes result
- div_quot  out  32  quotient
- div_rem  out  32  remainder
- div_busy  out  1  state != IDLE

## Operation
- States: IDLE, CALC, DONE.
- IDLE:
  - `div_ready=1`.
  - On `div_valid & div_ready & ~div_flush`, latch the following and go to CALC:
    - |src1| and |src2| (two's-complement magnitude when `div_signed` and the operand is negative, else raw).
    - Quotient sign = `div_signed & (src1[31]^src2[31])`.
    - Remainder sign = `div_signed & src1[31]`.
    - `div_by_zero = (src2==0)`.
    - Counter = 0.
- CALC: one restoring step per cycle on a 64-bit partial remainder.
  - Shift left 1.
  - Compare the upper 33 bits against the {0,|src2|}.
  - If greater or equal, subtract and shift in quotient bit 1; else shift in 0.
  - Counter increments each cycle. After the step with counter==31, go to DONE.
- Entry to DONE registers the results:
  - `div_quot` = quotient magnitude, negated if quotient sign is set.
  - `div_rem` = remainder magnitude, negated if remainder sign is set.
- Divide by zero: the result is overridden to `div_quot=32'hFFFF_FFFF`, `div_rem=div_src1` (original value), in both signed and unsigned modes. Latency is unchanged.
- Signed overflow: 0x8000_0000 / 0xFFFF_FFFF yields `div_quot=0x8000_0000`, `div_rem=0`. This falls out of the magnitude arithmetic; no special case.
- DONE:
  - `res_valid=1`; `div_quot`/`div_rem` are held stable.
  - On `res_valid & res_ready`, go to IDLE.
- Flush, from any state: next state is IDLE and `res_valid` is 0 the next cycle.
  - Flush has priority over accept and over the result handshake in the same cycle.
  - A flushed operation never produces `res_valid`.
- `div_quot`/`div_rem` hold their last values in IDLE and CALC; only entry to DONE updates them.

## Timing
- Reset, effective the cycle after `reset` is sampled high:
  - state=IDLE, counter=0
  - `div_quot=0`, `div_rem=0`, `res_valid=0`, `div_busy=0`, `div_ready=1`
- Outputs:
  - `div_ready` and `div_busy` are combinational from state.
  - `res_valid`, `div_quot` and `div_rem` are registered.
- Latency: if the accept handshake occurs in cycle T, `res_valid` is first high in cycle T+33 (32 CALC cycles, then DONE).
- Throughput: at most one operation per 34 cycles. The result handshake in DONE returns to IDLE, and a new accept is possible the following cycle.
- Backpressure: with `res_ready` low, the unit stays in DONE indefinitely with outputs stable.
- Input handling: `div_src1`/`div_src2`/`div_signed` are sampled only at accept. Changes afterward have no effect.
- Reset mid-operation: identical to the reset values above; no result is emitted.

## Test plan
- Unsigned 100/7, accept at T:
  - `res_valid` low through T+32 and high at T+33.
  - `div_quot=14`, `div_rem=2`.
  - `div_busy` high T+1..T+33 and low at T+34 after `res_ready`.
- Signed 0xFFFF_FFF9/2 (−7/2) -> `div_quot=0xFFFF_FFFD`, `div_rem=0xFFFF_FFFF`.
- Signed 7/0xFFFF_FFFE (7/−2) -> `div_quot=0xFFFF_FFFD`, `div_rem=1`.
- Signed 0x8000_0000/0xFFFF_FFFF -> `div_quot=0x8000_0000`, `div_rem=0`.
- Divide by zero, 5/0, signed and unsigned -> `div_quot=0xFFFF_FFFF`, `div_rem=5`, still at T+33.
- Flush and reset:
  - Assert `div_flush` in CALC cycle 10: next cycle `div_busy=0`, `div_ready=1`, and `res_valid` never rises.
  - A following request 9/3 returns `div_quot=3`, `div_rem=0`.
  - Assert `reset` mid-CALC: all outputs return to their reset values.
- Backpressure: hold `res_ready` low 5 cycles in DONE.
  - `res_valid` and outputs stay stable; a `div_valid` pulse is not accepted (`div_ready=0`).
  - After `res_ready`, the next request is accepted one cycle later.

Source files
------------

// File: rtl/div_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : div_ctrl
//  Description : Iterative 32-bit divider controller for the EX stage.
//                Accepts one div/mod request at a time over a valid/ready
//                handshake. It runs a restoring shift-subtract datapath that
//                produces one quotient bit per cycle. It then applies sign
//                correction and returns quotient and remainder together
//                over a second valid/ready handshake.
//
//  Ports       : clk        - clock, rising edge
//                reset      - synchronous active-high reset
//                div_valid  - request valid from EX
//                div_ready  - unit can accept a request (IDLE only)
//                div_signed - 1 = signed (div.w/mod.w), 0 = unsigned
//                div_src1   - dividend
//                div_src2   - divisor
//                div_flush  - cancel any in-flight operation
//                res_valid  - quotient/remainder valid
//                res_ready  - EX consumes result
//                div_quot   - quotient
//                div_rem    - remainder
//                div_busy   - unit not idle (EX holds the instruction)
//
//  Revision    : 1.0 - initial release
// ============================================================================
module div_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        div_valid,
    output logic        div_ready,
    input  logic        div_signed,
    input  logic [31:0] div_src1,
    input  logic [31:0] div_src2,
    input  logic        div_flush,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] div_quot,
    output logic [31:0] div_rem,
    output logic        div_busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [4:0] C_LAST_STEP = 5'd31;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]  r_state;
    logic [4:0]  r_cnt;
    logic [63:0] r_prem;      // {partial remainder, dividend/quotient bits}
    logic [31:0] r_dvsr;      // divisor magnitude
    logic [31:0] r_src1;      // original dividend, returned on divide-by-zero
    logic        r_qsign;
    logic        r_rsign;
    logic        r_dbz;
    logic        r_res_valid;
    logic [31:0] r_quot;
    logic [31:0] r_rem;

    logic [1:0]  w_state_nxt;
    logic [4:0]  w_cnt_nxt;
    logic [63:0] w_prem_nxt;
    logic [31:0] w_dvsr_nxt;
    logic [31:0] w_src1_nxt;
    logic        w_qsign_nxt;
    logic        w_rsign_nxt;
    logic        w_dbz_nxt;
    logic        w_res_valid_nxt;
    logic [31:0] w_quot_nxt;
    logic [31:0] w_rem_nxt;

    // ------------------------------------------------------------------
    // Operand magnitudes at accept
    // ------------------------------------------------------------------
    logic [31:0] w_abs1;
    logic [31:0] w_abs2;

    assign w_abs1 = (div_signed && div_src1[31]) ? (32'd0 - div_src1) : div_src1;
    assign w_abs2 = (div_signed && div_src2[31]) ? (32'd0 - div_src2) : div_src2;

    // ------------------------------------------------------------------
    // One restoring step. After the left shift the upper 33 bits are
    // {r_prem[63:31]}; bit 32 can only be set transiently, so when the
    // compare succeeds the difference always fits back into 32 bits.
    // ------------------------------------------------------------------
    logic [32:0] w_upper;
    logic        w_ge;
    logic [31:0] w_diff;
    logic [63:0] w_step;
    logic [31:0] w_quot_mag;
    logic [31:0] w_rem_mag;

    assign w_upper    = r_prem[63:31];
    assign w_ge       = (w_upper >= {1'b0, r_dvsr});
    assign w_diff     = w_upper[31:0] - r_dvsr;
    assign w_step     = w_ge ? {w_diff, r_prem[30:0], 1'b1}
                             : {w_upper[31:0], r_prem[30:0], 1'b0};
    assign w_quot_mag = w_step[31:0];
    assign w_rem_mag  = w_step[63:32];

    // ------------------------------------------------------------------
    // Next-state / datapath control
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_prem_nxt      = r_prem;
        w_dvsr_nxt      = r_dvsr;
        w_src1_nxt      = r_src1;
        w_qsign_nxt     = r_qsign;
        w_rsign_nxt     = r_rsign;
        w_dbz_nxt       = r_dbz;
        w_res_valid_nxt = r_res_valid;
        w_quot_nxt      = r_quot;
        w_rem_nxt       = r_rem;

        if (div_flush) begin
            // Flush beats both the accept and the result handshake.
            w_state_nxt     = S_IDLE;
            w_cnt_nxt       = 5'd0;
            w_res_valid_nxt = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (div_valid) begin
                        w_state_nxt = S_CALC;
                        w_cnt_nxt   = 5'd0;
                        w_prem_nxt  = {32'd0, w_abs1};
                        w_dvsr_nxt  = w_abs2;
                        w_src1_nxt  = div_src1;
                        w_qsign_nxt = div_signed & (div_src1[31] ^ div_src2[31]);
                        w_rsign_nxt = div_signed & div_src1[31];
                        w_dbz_nxt   = (div_src2 == 32'd0);
                    end
                end
                S_CALC: begin
                    w_prem_nxt = w_step;
                    w_cnt_nxt  = r_cnt + 5'd1;
                    if (r_cnt == C_LAST_STEP) begin
                        w_state_nxt     = S_DONE;
                        w_res_valid_nxt = 1'b1;
                        if (r_dbz) begin
                            w_quot_nxt = 32'hFFFF_FFFF;
                            w_rem_nxt  = r_src1;
                        end else begin
                            w_quot_nxt = r_qsign ? (32'd0 - w_quot_mag) : w_quot_mag;
                            w_rem_nxt  = r_rsign ? (32'd0 - w_rem_mag)  : w_rem_mag;
                        end
                    end
                end
                S_DONE: begin
                    if (res_ready) begin
                        w_state_nxt     = S_IDLE;
                        w_res_valid_nxt = 1'b0;
                    end
                end
                default: begin
                    w_state_nxt     = S_IDLE;
                    w_res_valid_nxt = 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= 5'd0;
            r_prem      <= 64'd0;
            r_dvsr      <= 32'd0;
            r_src1      <= 32'd0;
            r_qsign     <= 1'b0;
            r_rsign     <= 1'b0;
            r_dbz       <= 1'b0;
            r_res_valid <= 1'b0;
            r_quot      <= 32'd0;
            r_rem       <= 32'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_prem      <= w_prem_nxt;
            r_dvsr      <= w_dvsr_nxt;
            r_src1      <= w_src1_nxt;
            r_qsign     <= w_qsign_nxt;
            r_rsign     <= w_rsign_nxt;
            r_dbz       <= w_dbz_nxt;
            r_res_valid <= w_res_valid_nxt;
            r_quot      <= w_quot_nxt;
            r_rem       <= w_rem_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign div_ready = (r_state == S_IDLE);
    assign div_busy  = (r_state != S_IDLE);
    assign res_valid = r_res_valid;
    assign div_quot  = r_quot;
    assign div_rem   = r_rem;

endmodule
`default_nettype wire

// File: tb/tb_div_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_div_ctrl
//  Description : Self-checking bench for div_ctrl. Expected results come
//                from an arithmetic reference model of div/mod semantics.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_div_ctrl;

    logic        clk;
    logic        reset;
    logic        div_valid;
    logic        div_ready;
    logic        div_signed;
    logic [31:0] div_src1;
    logic [31:0] div_src2;
    logic        div_flush;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] div_quot;
    logic [31:0] div_rem;
    logic        div_busy;

    int checks;
    int errors;

    div_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .div_valid  (div_valid),
        .div_ready  (div_ready),
        .div_signed (div_signed),
        .div_src1   (div_src1),
        .div_src2   (div_src2),
        .div_flush  (div_flush),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .div_quot   (div_quot),
        .div_rem    (div_rem),
        .div_busy   (div_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: truncating division, remainder takes dividend sign.
    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  input logic s,
                                  output logic [31:0] q, output logic [31:0] r);
        int sa;
        int sb;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (s) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                q = 32'h8000_0000;
                r = 32'd0;
            end else begin
                sa = a;
                sb = b;
                q = sa / sb;
                r = sa % sb;
            end
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    // Drives one accept at the next edge and scrambles inputs afterwards.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s);
        div_src1   = a;
        div_src2   = b;
        div_signed = s;
        div_valid  = 1'b1;
        @(posedge clk); #1;
        div_valid  = 1'b0;
        div_src1   = $urandom;
        div_src2   = $urandom;
        div_signed = 1'($urandom_range(0, 1));
    endtask

    // Waits (bounded) for res_valid; lat = cycle offset from accept cycle T.
    task automatic wait_result(output int lat);
        lat = -1;
        for (int k = 0; k < 40; k++) begin
            if (res_valid) begin
                lat = k + 1;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic consume();
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                          output logic [31:0] q, output logic [31:0] r, output int lat);
        issue(a, b, s);
        wait_result(lat);
        q = div_quot;
        r = div_rem;
        if (lat > 0) consume();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        checks++;
        if (div_quot !== 32'd0 || div_rem !== 32'd0) begin
            errors++;
            $display("FAIL reset_data: quot=%h rem=%h required 0/0", div_quot, div_rem);
        end
        checks++;
        if (res_valid !== 1'b0 || div_busy !== 1'b0 || div_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ctrl: valid=%b busy=%b ready=%b required 0/0/1",
                     res_valid, div_busy, div_ready);
        end
    endtask

    task automatic test_basic_timing();
        int lat;
        bit early;
        bit busy_bad;
        issue(32'd100, 32'd7, 1'b0);
        lat = -1;
        early = 1'b0;
        busy_bad = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (div_busy !== 1'b1) busy_bad = 1'b1;
            if (res_valid) begin
                lat = k + 1;
                break;
            end
            @(posedge clk); #1;
        end
        checks++;
        if (lat != 33) begin
            errors++;
            $display("FAIL basic_latency: got %0d required 33", lat);
        end
        checks++;
        if (busy_bad) begin
            errors++;
            $display("FAIL basic_busy: busy dropped during T+1..T+33 required high");
        end
        checks++;
        if (div_quot !== 32'd14 || div_rem !== 32'd2) begin
            errors++;
            $display("FAIL basic_100_7: quot=%0d rem=%0d required 14/2", div_quot, div_rem);
        end
        consume();
        checks++;
        if (div_busy !== 1'b0 || div_ready !== 1'b1 || res_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_release: busy=%b ready=%b valid=%b required 0/1/0",
                     div_busy, div_ready, res_valid);
        end
        if (early) errors++;
    endtask

    task automatic test_directed();
        logic [31:0] va [6];
        logic [31:0] vb [6];
        logic        vs [6];
        logic [31:0] q, r, eq, er;
        int lat;
        va[0] = 32'hFFFF_FFF9; vb[0] = 32'd2;          vs[0] = 1'b1;
        va[1] = 32'd7;         vb[1] = 32'hFFFF_FFFE;  vs[1] = 1'b1;
        va[2] = 32'h8000_0000; vb[2] = 32'hFFFF_FFFF;  vs[2] = 1'b1;
        va[3] = 32'd5;         vb[3] = 32'd0;          vs[3] = 1'b1;
        va[4] = 32'd5;         vb[4] = 32'd0;          vs[4] = 1'b0;
        va[5] = 32'hFFFF_FFF9; vb[5] = 32'd0;          vs[5] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            model(va[i], vb[i], vs[i], eq, er);
            run_op(va[i], vb[i], vs[i], q, r, lat);
            checks++;
            if (q !== eq || r !== er || lat != 33) begin
                errors++;
                $display("FAIL directed_%0d: %h/%h s=%b got q=%h r=%h lat=%0d required q=%h r=%h lat=33",
                         i, va[i], vb[i], vs[i], q, r, lat, eq, er);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] a, b, q, r, eq, er;
        logic s;
        int lat;
        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            b = $urandom;
            s = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 5))
                0: b = 32'($urandom_range(1, 15));
                1: b = 32'd0 - 32'($urandom_range(1, 15));
                2: b = 32'd0;
                3: b = a;
                4: a = 32'($urandom_range(0, 100));
                default: ;
            endcase
            model(a, b, s, eq, er);
            run_op(a, b, s, q, r, lat);
            checks++;
            if (q !== eq || r !== er || lat != 33) begin
                errors++;
                $display("FAIL random_%0d: %h/%h s=%b got q=%h r=%h lat=%0d required q=%h r=%h lat=33",
                         i, a, b, s, q, r, lat, eq, er);
            end
        end
    endtask

    task automatic test_flush();
        logic [31:0] q, r;
        int lat;
        bit rose;
        issue(32'd1000, 32'd3, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        div_flush = 1'b1;
        @(posedge clk); #1;
        div_flush = 1'b0;
        checks++;
        if (div_busy !== 1'b0 || div_ready !== 1'b1 || res_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_idle: busy=%b ready=%b valid=%b required 0/1/0",
                     div_busy, div_ready, res_valid);
        end
        rose = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (res_valid) rose = 1'b1;
            @(posedge clk); #1;
        end
        checks++;
        if (rose) begin
            errors++;
            $display("FAIL flush_no_result: res_valid=1 after flush required 0");
        end
        // Flush wins over an accept in the same cycle.
        div_src1 = 32'd8; div_src2 = 32'd2; div_signed = 1'b0;
        div_valid = 1'b1; div_flush = 1'b1;
        @(posedge clk); #1;
        div_valid = 1'b0; div_flush = 1'b0;
        checks++;
        if (div_busy !== 1'b0) begin
            errors++;
            $display("FAIL flush_vs_accept: busy=%b required 0", div_busy);
        end
        run_op(32'd9, 32'd3, 1'b0, q, r, lat);
        checks++;
        if (q !== 32'd3 || r !== 32'd0 || lat != 33) begin
            errors++;
            $display("FAIL flush_follow_9_3: q=%0d r=%0d lat=%0d required 3/0/33", q, r, lat);
        end
    endtask

    task automatic test_reset_mid();
        bit rose;
        issue(32'd123456, 32'd789, 1'b0);
        repeat (12) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checks++;
        if (div_quot !== 32'd0 || div_rem !== 32'd0 || res_valid !== 1'b0 ||
            div_busy !== 1'b0 || div_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid: q=%h r=%h valid=%b busy=%b ready=%b required 0/0/0/0/1",
                     div_quot, div_rem, res_valid, div_busy, div_ready);
        end
        rose = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (res_valid) rose = 1'b1;
            @(posedge clk); #1;
        end
        checks++;
        if (rose) begin
            errors++;
            $display("FAIL reset_mid_no_result: res_valid rose required 0");
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] q0, r0, eq, er;
        int lat;
        bit unstable;
        model(32'd1234567, 32'd89, 1'b0, eq, er);
        issue(32'd1234567, 32'd89, 1'b0);
        wait_result(lat);
        q0 = div_quot;
        r0 = div_rem;
        checks++;
        if (q0 !== eq || r0 !== er || lat != 33) begin
            errors++;
            $display("FAIL bp_result: q=%0d r=%0d lat=%0d required %0d/%0d/33", q0, r0, lat, eq, er);
        end
        unstable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            div_src1 = $urandom; div_src2 = $urandom; div_valid = 1'b1;
            if (div_ready !== 1'b0) unstable = 1'b1;
            @(posedge clk); #1;
            if (res_valid !== 1'b1 || div_quot !== q0 || div_rem !== r0) unstable = 1'b1;
        end
        div_valid = 1'b0;
        checks++;
        if (unstable) begin
            errors++;
            $display("FAIL bp_hold: valid=%b q=%h r=%h required 1/%h/%h with ready low",
                     res_valid, div_quot, div_rem, q0, r0);
        end
        consume();
        checks++;
        if (div_ready !== 1'b1 || res_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_release: ready=%b valid=%b required 1/0", div_ready, res_valid);
        end
        model(32'hFFFF_FF00, 32'd16, 1'b1, eq, er);
        issue(32'hFFFF_FF00, 32'd16, 1'b1);
        checks++;
        if (div_busy !== 1'b1) begin
            errors++;
            $display("FAIL bp_next_accept: busy=%b required 1", div_busy);
        end
        wait_result(lat);
        checks++;
        if (div_quot !== eq || div_rem !== er || lat != 33) begin
            errors++;
            $display("FAIL bp_next_result: q=%h r=%h lat=%0d required %h/%h/33",
                     div_quot, div_rem, lat, eq, er);
        end
        if (lat > 0) consume();
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        reset      = 1'b0;
        div_valid  = 1'b0;
        div_signed = 1'b0;
        div_src1   = 32'd0;
        div_src2   = 32'd0;
        div_flush  = 1'b0;
        res_ready  = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_basic_timing();
        test_directed();
        test_random();
        test_flush();
        test_reset_mid();
        test_backpressure();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
